// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_INSTR, ARB_DATA} arb_state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Avalon-style memory port; master drives the request, slave answers with data/stall.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (output read, write, address, byteenable, writedata,
                    input  readdata, waitrequest);
    modport slave  (input  read, write, address, byteenable, writedata,
                    output readdata, waitrequest);
endinterface

// File: rtl/mem_arb_req_latch.sv
// Grant-time copy of the winning request; the memory side is driven only from here.
module mem_arb_req_latch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   ld_address,
    input  logic [DATA_W/8-1:0] ld_byteenable,
    input  logic [DATA_W-1:0]   ld_writedata,
    input  logic                ld_rd,
    input  logic                ld_wr,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    output logic                rd,
    output logic                wr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
        end else if (load) begin
            address    <= ld_address;
            byteenable <= ld_byteenable;
            writedata  <= ld_writedata;
            rd         <= ld_rd;
            wr         <= ld_wr;
        end else if (clr) begin
            // Only the strobes drop at completion; the bus fields keep their last value.
            rd <= 1'b0;
            wr <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data masters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  i_port,
    mem_port_arbiter_if.slave  d_port,
    mem_port_arbiter_if.master m_port
);
    arb_state_t state, nxt_state;
    grant_t     last_grant;
    logic       load, clr, sel_d, done_i, done_d;
    logic       req_i, req_d;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    // Fetch port never writes; these fields exist only because the bus type is shared.
    logic unused_fetch_bits;
    assign unused_fetch_bits = &{1'b0, i_port.write, i_port.byteenable, i_port.writedata};

    assign req_i = i_port.read;
    assign req_d = d_port.read | d_port.write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_DATA;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= nxt_state;
            if (done_i) begin
                last_grant <= GRANT_INSTR;
                i_rdata_q  <= m_port.readdata;
            end
            if (done_d) begin
                last_grant <= GRANT_DATA;
                if (m_port.read) d_rdata_q <= m_port.readdata;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        clr       = 1'b0;
        sel_d     = 1'b0;
        done_i    = 1'b0;
        done_d    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (req_i && (!req_d || last_grant == GRANT_DATA)) begin
                    nxt_state = ARB_INSTR;
                    load      = 1'b1;
                end else if (req_d) begin
                    nxt_state = ARB_DATA;
                    load      = 1'b1;
                    sel_d     = 1'b1;
                end
            end
            ARB_INSTR: begin
                if (!m_port.waitrequest) begin
                    done_i    = 1'b1;
                    clr       = 1'b1;
                    nxt_state = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (!m_port.waitrequest) begin
                    done_d    = 1'b1;
                    clr       = 1'b1;
                    nxt_state = ARB_IDLE;
                end
            end
            default: nxt_state = ARB_IDLE;
        endcase
    end

    mem_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_latch (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .clr           (clr),
        .ld_address    (sel_d ? d_port.address : i_port.address),
        .ld_byteenable (sel_d ? d_port.byteenable : {(DATA_W/8){1'b1}}),
        .ld_writedata  (sel_d ? d_port.writedata : '0),
        // A read+write collision from the data master resolves to the write.
        .ld_rd         (sel_d ? (d_port.read & ~d_port.write) : 1'b1),
        .ld_wr         (sel_d & d_port.write),
        .address       (m_port.address),
        .byteenable    (m_port.byteenable),
        .writedata     (m_port.writedata),
        .rd            (m_port.read),
        .wr            (m_port.write)
    );

    assign i_port.waitrequest = req_i & ~done_i;
    assign d_port.waitrequest = req_d & ~done_d;
    assign i_port.readdata    = done_i ? m_port.readdata : i_rdata_q;
    assign d_port.readdata    = done_d ? m_port.readdata : d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a waitstate memory model and per-master scoreboards.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_port (i_bus),
        .d_port (d_bus),
        .m_port (m_bus)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h8C02_0000;
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    // Memory: fixed number of wait cycles per access, data valid when waitrequest drops.
    int waits_cfg = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        if ((m_bus.read || m_bus.write) && wcnt != 0) wcnt <= wcnt - 1;
        else wcnt <= waits_cfg;
    end
    assign m_bus.waitrequest = (wcnt != 0);
    assign m_bus.readdata    = mem_data(m_bus.address);

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    txn_t i_pend[$], d_pend[$], i_exp[$], d_exp[$];
    int   i_log[$], d_log[$];
    bit   i_done = 0, d_done = 0;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick();
        if (!i_bus.read && i_pend.size() > 0) begin
            txn_t t;
            t = i_pend.pop_front();
            i_bus.read    = 1'b1;
            i_bus.address = t.addr;
            t.data = mem_data(t.addr);
            i_exp.push_back(t);
        end
        if (!d_bus.read && !d_bus.write && d_pend.size() > 0) begin
            txn_t t;
            t = d_pend.pop_front();
            d_bus.read       = t.rd;
            d_bus.write      = t.wr;
            d_bus.address    = t.addr;
            d_bus.byteenable = t.be;
            d_bus.writedata  = t.data;
            if (!t.wr) t.data = mem_data(t.addr);
            d_exp.push_back(t);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (i_bus.read && !i_bus.waitrequest) begin
            i_done = 1;
            i_log.push_back(cyc);
            chk("i_outstanding", i_exp.size(), 1);
            if (i_exp.size() > 0) begin
                txn_t t;
                t = i_exp.pop_front();
                chk("i_readdata", i_bus.readdata, t.data);
                chk("i_m_address", m_bus.address, t.addr);
                chk("i_m_rdwr", {m_bus.read, m_bus.write}, 2'b10);
                chk("i_m_be", m_bus.byteenable, 4'hF);
            end
        end
        if ((d_bus.read || d_bus.write) && !d_bus.waitrequest) begin
            d_done = 1;
            d_log.push_back(cyc);
            chk("d_outstanding", d_exp.size(), 1);
            if (d_exp.size() > 0) begin
                txn_t t;
                t = d_exp.pop_front();
                chk("d_m_address", m_bus.address, t.addr);
                chk("d_m_be", m_bus.byteenable, t.be);
                if (t.wr) begin
                    chk("d_m_rdwr_wr", {m_bus.read, m_bus.write}, 2'b01);
                    chk("d_m_writedata", m_bus.writedata, t.data);
                end else begin
                    chk("d_m_rdwr_rd", {m_bus.read, m_bus.write}, 2'b10);
                    chk("d_readdata", d_bus.readdata, t.data);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        if (i_done) begin i_bus.read = 1'b0; i_done = 0; end
        if (d_done) begin d_bus.read = 1'b0; d_bus.write = 1'b0; d_done = 0; end
        kick();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((i_pend.size() + d_pend.size() + i_exp.size() + d_exp.size()) != 0 && n < budget) begin
            sample();
            adv();
            n++;
        end
        chk("drain_in_budget", i_pend.size() + d_pend.size() + i_exp.size() + d_exp.size(), 0);
    endtask

    function automatic txn_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.be = be; t.data = d;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        i_bus.read = 0; i_bus.write = 0; i_bus.address = '0; i_bus.byteenable = '0; i_bus.writedata = '0;
        d_bus.read = 0; d_bus.write = 0; d_bus.address = '0; d_bus.byteenable = '0; d_bus.writedata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_rdwr", {m_bus.read, m_bus.write}, 2'b00);
        chk("rst_m_address", m_bus.address, 0);
        chk("rst_m_be", m_bus.byteenable, 0);
        chk("rst_m_wdata", m_bus.writedata, 0);
        chk("rst_i_rdata", i_bus.readdata, 0);
        chk("rst_d_rdata", d_bus.readdata, 0);
        i_bus.read = 1; d_bus.read = 1;
        #1;
        chk("rst_i_wait", i_bus.waitrequest, 1);
        chk("rst_d_wait", d_bus.waitrequest, 1);
        i_bus.read = 0; d_bus.read = 0;
        @(posedge clk); #1 rst_n = 1;

        // First tie after reset goes to fetch, then grants alternate
        i_pend.push_back(mk(1, 0, 32'h0, 4'hF, 0));
        i_pend.push_back(mk(1, 0, 32'h8, 4'hF, 0));
        d_pend.push_back(mk(1, 0, 32'h4, 4'hF, 0));
        d_pend.push_back(mk(1, 0, 32'hC, 4'hF, 0));
        c0 = cyc;
        kick();
        run(30);
        chk("tie_log_sizes", {i_log.size(), d_log.size()}, {32'd2, 32'd2});
        if (i_log.size() == 2 && d_log.size() == 2) begin
            chk("tie_i0_cycle", i_log[0] - c0, 1);
            chk("tie_d0_cycle", d_log[0] - c0, 3);
            chk("tie_i1_cycle", i_log[1] - c0, 5);
            chk("tie_d1_cycle", d_log[1] - c0, 7);
        end
        sample();
        chk("i_rdata_hold", i_bus.readdata, mem_data(32'h8));
        chk("d_rdata_hold", d_bus.readdata, mem_data(32'hC));
        adv();

        // Fetch only, zero waits
        i_pend.push_back(mk(1, 0, 32'hBFC0_0000, 4'hF, 0));
        kick();
        sample();
        chk("f_c1_i_wait", i_bus.waitrequest, 1);
        chk("f_c1_d_wait", d_bus.waitrequest, 0);
        adv();
        sample();
        chk("f_c2_i_wait", i_bus.waitrequest, 0);
        chk("f_c2_i_rdata", i_bus.readdata, 32'h8C02_0000);
        chk("f_c2_d_wait", d_bus.waitrequest, 0);
        adv();

        // Store with 3 wait cycles: bus stable over all 4 busy cycles
        waits_cfg = 3;
        d_pend.push_back(mk(0, 1, 32'h103, 4'b1000, 32'hAB00_0000));
        kick();
        sample();
        chk("st_idle_d_wait", d_bus.waitrequest, 1);
        adv();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("st_m_write", {m_bus.read, m_bus.write}, 2'b01);
            chk("st_m_address", m_bus.address, 32'h103);
            chk("st_m_be", m_bus.byteenable, 4'b1000);
            chk("st_m_wdata", m_bus.writedata, 32'hAB00_0000);
            chk("st_d_wait", d_bus.waitrequest, (k == 3) ? 1'b0 : 1'b1);
            adv();
        end
        waits_cfg = 0;
        run(5);

        // Read and write together: write wins
        d_pend.push_back(mk(1, 1, 32'h50, 4'hF, 32'h1234_5678));
        kick();
        run(10);

        // Master drops read after grant: latched read runs to completion
        waits_cfg = 2;
        d_bus.read = 1; d_bus.address = 32'h20; d_bus.byteenable = 4'hF;
        sample();
        adv();
        sample();
        chk("drop_b1_m_read", {m_bus.read, m_bus.write}, 2'b10);
        chk("drop_b1_m_addr", m_bus.address, 32'h20);
        adv();
        d_bus.read = 0; d_bus.address = 32'h999;
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("drop_m_read", {m_bus.read, m_bus.write}, 2'b10);
            chk("drop_m_addr", m_bus.address, 32'h20);
            chk("drop_d_wait", d_bus.waitrequest, 0);
            adv();
        end
        sample();
        chk("drop_idle_m_read", {m_bus.read, m_bus.write}, 2'b00);
        adv();
        waits_cfg = 0;

        // Fetch so the last grant is instruction, then reset mid data transfer
        i_pend.push_back(mk(1, 0, 32'h100, 4'hF, 0));
        kick();
        run(10);
        waits_cfg = 5;
        d_pend.push_back(mk(1, 0, 32'h40, 4'hF, 0));
        kick();
        sample();
        adv();
        sample();
        chk("rsb_m_read", {m_bus.read, m_bus.write}, 2'b10);
        adv();
        #2 rst_n = 0;
        #1;
        chk("rsm_m_rdwr", {m_bus.read, m_bus.write}, 2'b00);
        chk("rsm_m_addr", m_bus.address, 0);
        d_exp.delete();
        d_bus.read = 0;
        waits_cfg = 0;
        @(posedge clk); #1 rst_n = 1;
        sample();
        chk("rsm_i_rdata_clr", i_bus.readdata, 0);
        adv();
        i_log.delete(); d_log.delete();
        i_pend.push_back(mk(1, 0, 32'h200, 4'hF, 0));
        d_pend.push_back(mk(1, 0, 32'h204, 4'hF, 0));
        c0 = cyc;
        kick();
        run(20);
        chk("rst_tie_sizes", {i_log.size(), d_log.size()}, {32'd1, 32'd1});
        if (i_log.size() == 1 && d_log.size() == 1) begin
            chk("rst_tie_i_cycle", i_log[0] - c0, 1);
            chk("rst_tie_d_cycle", d_log[0] - c0, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
